// File: rtl/ucsbece154b_branch_predictor_pkg.sv
// ucsbece154b_branch_predictor_pkg
//   Shared definitions for the gshare + BTB branch predictor:
//   - 2-bit PHT counter encodings (strong/weak not-taken/taken)
//   - PHT reset value (weakly not-taken)
//   - data-path width
package ucsbece154b_branch_predictor_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    PHT_STRONG_NT = 2'b00,
    PHT_WEAK_NT   = 2'b01,
    PHT_WEAK_T    = 2'b10,
    PHT_STRONG_T  = 2'b11
  } pht_state_t;

  localparam logic [1:0] PHT_RESET_VAL = 2'(PHT_WEAK_NT);

endpackage

// File: rtl/ucsbece154b_branch_predictor_if.sv
// ucsbece154b_branch_predictor_if
//   Groups the fetch-side lookup and execute-side training signals of the
//   branch predictor.
//   master : pipeline datapath (drives PCs and resolved E-stage outcomes)
//   slave  : predictor (drives prediction, gshare index and mispredict)
//   NUM_GHR_BITS must match the predictor instance's NUM_GHR_BITS.
//   Fetch  : PCF_i -> BranchTakenF_o, BTBtargetF_o, PHTindexF_o
//   Execute: PredTakenE_i, PHTindexE_i, PCE_i, PCTargetE_i, BranchE_i,
//            JumpE_i, BranchTakenE_i -> MispredictE_o
interface ucsbece154b_branch_predictor_if #(
  parameter int NUM_GHR_BITS = 5
);

  logic [31:0]             PCF_i;
  logic                    BranchTakenF_o;
  logic [31:0]             BTBtargetF_o;
  logic [NUM_GHR_BITS-1:0] PHTindexF_o;

  logic                    PredTakenE_i;
  logic [NUM_GHR_BITS-1:0] PHTindexE_i;
  logic [31:0]             PCE_i;
  logic [31:0]             PCTargetE_i;
  logic                    BranchE_i;
  logic                    JumpE_i;
  logic                    BranchTakenE_i;
  logic                    MispredictE_o;

  modport master (
    output PCF_i,
    input  BranchTakenF_o,
    input  BTBtargetF_o,
    input  PHTindexF_o,
    output PredTakenE_i,
    output PHTindexE_i,
    output PCE_i,
    output PCTargetE_i,
    output BranchE_i,
    output JumpE_i,
    output BranchTakenE_i,
    input  MispredictE_o
  );

  modport slave (
    input  PCF_i,
    output BranchTakenF_o,
    output BTBtargetF_o,
    output PHTindexF_o,
    input  PredTakenE_i,
    input  PHTindexE_i,
    input  PCE_i,
    input  PCTargetE_i,
    input  BranchE_i,
    input  JumpE_i,
    input  BranchTakenE_i,
    output MispredictE_o
  );

endinterface

// File: rtl/ucsbece154b_branch_predictor_sat_counter2.sv
// ucsbece154b_sat_counter2
//   Next-state function of a 2-bit saturating direction counter.
//   count_i : current counter value
//   taken_i : resolved direction (1 = taken)
//   count_o : updated counter, saturating at 2'b11 and 2'b00
module ucsbece154b_sat_counter2
  import ucsbece154b_branch_predictor_pkg::*;
(
  input  logic [1:0] count_i,
  input  logic       taken_i,
  output logic [1:0] count_o
);

  always_comb begin
    count_o = count_i;
    if (taken_i) begin
      if (count_i != 2'(PHT_STRONG_T)) count_o = count_i + 2'd1;
    end else begin
      if (count_i != 2'(PHT_STRONG_NT)) count_o = count_i - 2'd1;
    end
  end

endmodule

// File: rtl/ucsbece154b_branch_predictor.sv
// ucsbece154b_branch_predictor
//   Gshare direction predictor plus direct-mapped BTB.
//   Fetch lookup is combinational from registered state; training and
//   mispredict detection use the resolved execute-stage outcome.
//   Ports:
//     clk    : clock, all state updates on the rising edge
//     reset  : synchronous, active-low
//     bp     : ucsbece154b_branch_predictor_if.slave (fetch + execute signals)
//   Optional feature, macro UCSBECE154B_BP_PERF_COUNTERS_EN:
//     BranchCount_o     : cycles with a branch or jal in E (wraps at 2^32)
//     MispredictCount_o : cycles with MispredictE_o set    (wraps at 2^32)
module ucsbece154b_branch_predictor
  import ucsbece154b_branch_predictor_pkg::*;
#(
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int NUM_GHR_BITS    = 5
) (
  input  logic clk,
  input  logic reset,
  ucsbece154b_branch_predictor_if.slave bp
`ifdef UCSBECE154B_BP_PERF_COUNTERS_EN
  ,
  output logic [31:0] BranchCount_o,
  output logic [31:0] MispredictCount_o
`endif
);

  localparam int IDX_BITS  = $clog2(NUM_BTB_ENTRIES);
  localparam int TAG_BITS  = XLEN - IDX_BITS - 2;
  localparam int PHT_DEPTH = 1 << NUM_GHR_BITS;

  logic                    btbValid  [NUM_BTB_ENTRIES];
  logic [TAG_BITS-1:0]     btbTag    [NUM_BTB_ENTRIES];
  logic [31:0]             btbTarget [NUM_BTB_ENTRIES];
  logic                    btbIsJump [NUM_BTB_ENTRIES];
  logic [1:0]              pht       [PHT_DEPTH];
  logic [NUM_GHR_BITS-1:0] ghr;

  // Fetch lookup
  logic [IDX_BITS-1:0]     fIdx;
  logic [TAG_BITS-1:0]     fTag;
  logic                    fHit;
  logic [NUM_GHR_BITS-1:0] phtIdxF;

  assign fIdx    = bp.PCF_i[IDX_BITS+1:2];
  assign fTag    = bp.PCF_i[31:IDX_BITS+2];
  assign fHit    = btbValid[fIdx] && (btbTag[fIdx] == fTag);
  assign phtIdxF = bp.PCF_i[NUM_GHR_BITS+1:2] ^ ghr;

  assign bp.PHTindexF_o    = phtIdxF;
  assign bp.BranchTakenF_o = fHit & (btbIsJump[fIdx] | pht[phtIdxF][1]);
  assign bp.BTBtargetF_o   = fHit ? btbTarget[fIdx] : 32'd0;

  // Execute training
  logic [IDX_BITS-1:0]     eIdx;
  logic [TAG_BITS-1:0]     eTag;
  logic                    btbWrite;
  logic                    phtWrite;
  logic [1:0]              phtCur;
  logic [1:0]              phtNext;
  logic [NUM_GHR_BITS-1:0] ghrNext;
  logic                    mispredictE;

  assign eIdx     = bp.PCE_i[IDX_BITS+1:2];
  assign eTag     = bp.PCE_i[31:IDX_BITS+2];
  // A jal always (re)allocates; a branch only allocates when taken, so a
  // not-taken branch can never create a BTB entry that redirects fetch.
  assign btbWrite = bp.JumpE_i | (bp.BranchE_i & bp.BranchTakenE_i);
  assign phtWrite = bp.BranchE_i & ~bp.JumpE_i;
  assign phtCur   = pht[bp.PHTindexE_i];
  // Shift form works for every history length including a single bit.
  assign ghrNext  = (ghr << 1) | NUM_GHR_BITS'(bp.BranchTakenE_i);

  ucsbece154b_sat_counter2 u_sat_counter2 (
    .count_i (phtCur),
    .taken_i (bp.BranchTakenE_i),
    .count_o (phtNext)
  );

  // Last term: fetch followed a stale BTB hit on a non-control instruction.
  assign mispredictE = (bp.BranchE_i & (bp.PredTakenE_i ^ bp.BranchTakenE_i))
                     | (bp.JumpE_i & ~bp.PredTakenE_i)
                     | (~bp.BranchE_i & ~bp.JumpE_i & bp.PredTakenE_i);

  assign bp.MispredictE_o = mispredictE;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BTB_ENTRIES; i++) btbValid[i] <= 1'b0;
      for (int i = 0; i < PHT_DEPTH; i++)       pht[i]      <= PHT_RESET_VAL;
      ghr <= '0;
    end else begin
      if (btbWrite) btbValid[eIdx] <= 1'b1;
      if (phtWrite) begin
        pht[bp.PHTindexE_i] <= phtNext;
        ghr                 <= ghrNext;
      end
    end
  end

  // BTB payload needs no reset: it is qualified by btbValid.
  always_ff @(posedge clk) begin
    if (reset && btbWrite) begin
      btbTag[eIdx]    <= eTag;
      btbTarget[eIdx] <= bp.PCTargetE_i;
      btbIsJump[eIdx] <= bp.JumpE_i;
    end
  end

`ifdef UCSBECE154B_BP_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      BranchCount_o     <= '0;
      MispredictCount_o <= '0;
    end else begin
      if (bp.BranchE_i | bp.JumpE_i) BranchCount_o     <= BranchCount_o + 32'd1;
      if (mispredictE)               MispredictCount_o <= MispredictCount_o + 32'd1;
    end
  end
`endif

  // PC byte-offset bits carry no information for instruction addresses.
  logic unusedPcBits;
  assign unusedPcBits = ^{bp.PCF_i[1:0], bp.PCE_i[1:0]};

endmodule

// File: tb/tb_ucsbece154b_branch_predictor.sv
module tb_ucsbece154b_branch_predictor;

  localparam int N    = 32;
  localparam int G    = 5;
  localparam int IDXB = 5;
  localparam int MASK = (1 << G) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ucsbece154b_branch_predictor_if #(.NUM_GHR_BITS(G)) bpIf();

`ifdef UCSBECE154B_BP_PERF_COUNTERS_EN
  logic [31:0] branchCount, mispredictCount;
`endif

  ucsbece154b_branch_predictor #(
    .NUM_BTB_ENTRIES (N),
    .NUM_GHR_BITS    (G)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bpIf)
`ifdef UCSBECE154B_BP_PERF_COUNTERS_EN
    ,
    .BranchCount_o     (branchCount),
    .MispredictCount_o (mispredictCount)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model
  bit          mValid  [N];
  int unsigned mTag    [N];
  logic [31:0] mTarget [N];
  bit          mJump   [N];
  int          mPht    [1 << G];
  int unsigned mGhr;
  logic [31:0] mBrCnt, mMpCnt;

  function automatic int unsigned btbIdx(logic [31:0] pc);
    return (pc >> 2) % N;
  endfunction

  function automatic int unsigned btbTagOf(logic [31:0] pc);
    return pc >> (IDXB + 2);
  endfunction

  function automatic int unsigned mPhtIdx(logic [31:0] pc);
    return ((pc >> 2) ^ mGhr) & MASK;
  endfunction

  function automatic bit mHit(logic [31:0] pc);
    int unsigned i = btbIdx(pc);
    return mValid[i] && (mTag[i] == btbTagOf(pc));
  endfunction

  function automatic bit mPredTaken(logic [31:0] pc);
    return mHit(pc) && (mJump[btbIdx(pc)] || (mPht[mPhtIdx(pc)] >= 2));
  endfunction

  function automatic logic [31:0] mPredTarget(logic [31:0] pc);
    return mHit(pc) ? mTarget[btbIdx(pc)] : 32'd0;
  endfunction

  function automatic bit mMisp();
    bit br, jmp, pred, tk;
    br = bpIf.BranchE_i; jmp = bpIf.JumpE_i; pred = bpIf.PredTakenE_i; tk = bpIf.BranchTakenE_i;
    return (br && (pred != tk)) || (jmp && !pred) || (!br && !jmp && pred);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mValid[i] = 0;
    for (int i = 0; i < (1 << G); i++) mPht[i] = 1;
    mGhr = 0;
    mBrCnt = 0;
    mMpCnt = 0;
  endtask

  task automatic model_write_btb(logic [31:0] pc, logic [31:0] tgt, bit isJump);
    int unsigned i = btbIdx(pc);
    mValid[i]  = 1;
    mTag[i]    = btbTagOf(pc);
    mTarget[i] = tgt;
    mJump[i]   = isJump;
  endtask

  task automatic model_update(bit misp);
    int unsigned p;
    if (!reset) begin
      model_reset();
      return;
    end
    if (bpIf.BranchE_i || bpIf.JumpE_i) mBrCnt = mBrCnt + 1;
    if (misp) mMpCnt = mMpCnt + 1;
    if (bpIf.JumpE_i) begin
      model_write_btb(bpIf.PCE_i, bpIf.PCTargetE_i, 1);
    end else if (bpIf.BranchE_i) begin
      p = bpIf.PHTindexE_i;
      if (bpIf.BranchTakenE_i) mPht[p] = (mPht[p] == 3) ? 3 : mPht[p] + 1;
      else                     mPht[p] = (mPht[p] == 0) ? 0 : mPht[p] - 1;
      mGhr = ((mGhr << 1) | int'(bpIf.BranchTakenE_i)) & MASK;
      if (bpIf.BranchTakenE_i) model_write_btb(bpIf.PCE_i, bpIf.PCTargetE_i, 0);
    end
  endtask

  // Inputs are driven at the negedge; the model follows the DUT at the posedge.
  task automatic tick();
    bit m;
    m = mMisp();
    @(posedge clk);
    model_update(m);
    @(negedge clk);
  endtask

  task automatic drive_e(bit br, bit jmp, bit tk, bit pred,
                         logic [31:0] pce, logic [31:0] tgt, logic [G-1:0] pidx);
    bpIf.BranchE_i      = br;
    bpIf.JumpE_i        = jmp;
    bpIf.BranchTakenE_i = tk;
    bpIf.PredTakenE_i   = pred;
    bpIf.PCE_i          = pce;
    bpIf.PCTargetE_i    = tgt;
    bpIf.PHTindexE_i    = pidx;
  endtask

  task automatic idle_e();
    drive_e(0, 0, 0, 0, 32'd0, 32'd0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_e();
    bpIf.PCF_i = 32'd0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Five not-taken branches at an unrelated PHT slot return GHR to zero.
  task automatic flush_ghr();
    for (int i = 0; i < G; i++) begin
      drive_e(1, 0, 0, 0, 32'h00010400, 32'd0, 5'h1F);
      tick();
    end
    idle_e();
  endtask

  task automatic test_reset();
    do_reset();
    bpIf.PCF_i = 32'h00010000;
    #1;
    checks++;
    if (bpIf.BranchTakenF_o !== 1'b0) begin
      errors++; $display("FAIL reset_taken: got %0b expected 0", bpIf.BranchTakenF_o);
    end
    checks++;
    if (bpIf.BTBtargetF_o !== 32'd0) begin
      errors++; $display("FAIL reset_target: got %h expected 00000000", bpIf.BTBtargetF_o);
    end
    checks++;
    if (bpIf.PHTindexF_o !== 5'h00) begin
      errors++; $display("FAIL reset_phtidx: got %h expected 00", bpIf.PHTindexF_o);
    end
  endtask

  task automatic test_jump();
    drive_e(0, 1, 0, 0, 32'h00010010, 32'h00010040, '0);
    #1;
    checks++;
    if (bpIf.MispredictE_o !== 1'b1) begin
      errors++; $display("FAIL jump_misp: got %0b expected 1", bpIf.MispredictE_o);
    end
    tick();
    idle_e();
    bpIf.PCF_i = 32'h00010010;
    #1;
    checks++;
    if (bpIf.BranchTakenF_o !== 1'b1) begin
      errors++; $display("FAIL jump_taken: got %0b expected 1", bpIf.BranchTakenF_o);
    end
    checks++;
    if (bpIf.BTBtargetF_o !== 32'h00010040) begin
      errors++; $display("FAIL jump_target: got %h expected 00010040", bpIf.BTBtargetF_o);
    end
  endtask

  task automatic test_same_cycle();
    drive_e(0, 1, 0, 1, 32'h00010010, 32'h00010080, '0);
    bpIf.PCF_i = 32'h00010010;
    #1;
    checks++;
    if (bpIf.BTBtargetF_o !== 32'h00010040) begin
      errors++; $display("FAIL same_cycle_old: got %h expected 00010040", bpIf.BTBtargetF_o);
    end
    checks++;
    if (bpIf.MispredictE_o !== 1'b0) begin
      errors++; $display("FAIL same_cycle_misp: got %0b expected 0", bpIf.MispredictE_o);
    end
    tick();
    idle_e();
    #1;
    checks++;
    if (bpIf.BTBtargetF_o !== 32'h00010080) begin
      errors++; $display("FAIL same_cycle_new: got %h expected 00010080", bpIf.BTBtargetF_o);
    end
  endtask

  task automatic test_stale_hit();
    drive_e(0, 0, 0, 1, 32'h00010010, 32'h12345678, 5'h03);
    bpIf.PCF_i = 32'h00010010;
    #1;
    checks++;
    if (bpIf.MispredictE_o !== 1'b1) begin
      errors++; $display("FAIL stale_misp: got %0b expected 1", bpIf.MispredictE_o);
    end
    tick();
    idle_e();
    #1;
    checks++;
    if (bpIf.BTBtargetF_o !== 32'h00010080 || bpIf.BranchTakenF_o !== 1'b1) begin
      errors++; $display("FAIL stale_nochange_btb: got %h/%0b expected 00010080/1",
                         bpIf.BTBtargetF_o, bpIf.BranchTakenF_o);
    end
    checks++;
    if (bpIf.PHTindexF_o !== 5'h04) begin
      errors++; $display("FAIL stale_nochange_ghr: got %h expected 04", bpIf.PHTindexF_o);
    end
  endtask

  task automatic test_not_taken_alloc();
    do_reset();
    drive_e(1, 0, 0, 0, 32'h00010050, 32'h00010100, 5'h14);
    #1;
    checks++;
    if (bpIf.MispredictE_o !== 1'b0) begin
      errors++; $display("FAIL nt_alloc_misp: got %0b expected 0", bpIf.MispredictE_o);
    end
    tick();
    idle_e();
    bpIf.PCF_i = 32'h00010050;
    #1;
    checks++;
    if (bpIf.BranchTakenF_o !== 1'b0 || bpIf.BTBtargetF_o !== 32'd0) begin
      errors++; $display("FAIL nt_alloc_miss: got %0b/%h expected 0/00000000",
                         bpIf.BranchTakenF_o, bpIf.BTBtargetF_o);
    end
    checks++;
    if (bpIf.PHTindexF_o !== 5'h14) begin
      errors++; $display("FAIL nt_alloc_idx: got %h expected 14", bpIf.PHTindexF_o);
    end
  endtask

  task automatic test_branch_saturation();
    logic [31:0] bpc = 32'h0001002C;
    logic [31:0] btg = 32'h00010020;
    do_reset();
    // First taken resolution: counter 01->10, GHR=00001
    drive_e(1, 0, 1, 0, bpc, btg, 5'h0B);
    #1;
    checks++;
    if (bpIf.MispredictE_o !== 1'b1) begin
      errors++; $display("FAIL sat_first_misp: got %0b expected 1", bpIf.MispredictE_o);
    end
    tick();
    idle_e();
    bpIf.PCF_i = bpc;
    #1;
    checks++;
    if (bpIf.PHTindexF_o !== 5'h0A) begin
      errors++; $display("FAIL sat_ghr_one: got %h expected 0A", bpIf.PHTindexF_o);
    end
    checks++;
    if (bpIf.BranchTakenF_o !== 1'b0 || bpIf.BTBtargetF_o !== btg) begin
      errors++; $display("FAIL sat_alloc: got %0b/%h expected 0/%h",
                         bpIf.BranchTakenF_o, bpIf.BTBtargetF_o, btg);
    end
    flush_ghr();
    #1;
    checks++;
    if (bpIf.BranchTakenF_o !== 1'b1 || bpIf.PHTindexF_o !== 5'h0B) begin
      errors++; $display("FAIL sat_weak_taken: got %0b/%h expected 1/0B",
                         bpIf.BranchTakenF_o, bpIf.PHTindexF_o);
    end
    // 10->11, then 11 stays 11
    for (int i = 0; i < 2; i++) begin
      drive_e(1, 0, 1, 1, bpc, btg, 5'h0B);
      tick();
    end
    // 11->10, GHR 00011 -> 00110
    drive_e(1, 0, 0, 1, bpc, btg, 5'h0B);
    tick();
    idle_e();
    #1;
    checks++;
    if (bpIf.PHTindexF_o !== 5'h0D) begin
      errors++; $display("FAIL sat_ghr_shift0: got %h expected 0D", bpIf.PHTindexF_o);
    end
    flush_ghr();
    #1;
    checks++;
    if (bpIf.BranchTakenF_o !== 1'b1) begin
      errors++; $display("FAIL sat_high_hold: got %0b expected 1", bpIf.BranchTakenF_o);
    end
    // 10->01 : now predicted not-taken
    drive_e(1, 0, 0, 1, bpc, btg, 5'h0B);
    tick();
    flush_ghr();
    #1;
    checks++;
    if (bpIf.BranchTakenF_o !== 1'b0 || mPredTaken(bpc) !== 1'b0) begin
      errors++; $display("FAIL sat_down: got %0b expected 0", bpIf.BranchTakenF_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] pce, pcf, tgt;
    logic [G-1:0] pidx;
    int kind;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      pce = ($urandom_range(0, 3) == 0 ? 32'h00020000 : 32'h00010000) + ($urandom_range(0, 47) << 2);
      pcf = ($urandom_range(0, 3) == 0 ? 32'h00020000 : 32'h00010000) + ($urandom_range(0, 47) << 2);
      tgt = {$urandom} & 32'hFFFFFFFC;
      pidx = ($urandom_range(0, 1) == 1) ? G'(mPhtIdx(pce)) : G'($urandom);
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1, 2, 3: drive_e(1, 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, pce, tgt, pidx);
        4, 5:       drive_e(0, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, pce, tgt, pidx);
        6:          drive_e(1, 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, pce, tgt, pidx);
        7:          drive_e(0, 0, $urandom_range(0, 1) == 1, 1, pce, tgt, pidx);
        default:    drive_e(0, 0, $urandom_range(0, 1) == 1, 0, pce, tgt, pidx);
      endcase
      bpIf.PCF_i = pcf;
      #1;
      checks++;
      if (bpIf.BranchTakenF_o !== mPredTaken(pcf) || bpIf.BTBtargetF_o !== mPredTarget(pcf)) begin
        errors++; $display("FAIL rand_lookup pc=%h: got %0b/%h expected %0b/%h", pcf,
                           bpIf.BranchTakenF_o, bpIf.BTBtargetF_o, mPredTaken(pcf), mPredTarget(pcf));
      end
      checks++;
      if (bpIf.PHTindexF_o !== G'(mPhtIdx(pcf))) begin
        errors++; $display("FAIL rand_phtidx pc=%h: got %h expected %h", pcf,
                           bpIf.PHTindexF_o, G'(mPhtIdx(pcf)));
      end
      checks++;
      if (bpIf.MispredictE_o !== mMisp()) begin
        errors++; $display("FAIL rand_misp: got %0b expected %0b", bpIf.MispredictE_o, mMisp());
      end
`ifdef UCSBECE154B_BP_PERF_COUNTERS_EN
      checks++;
      if (branchCount !== mBrCnt || mispredictCount !== mMpCnt) begin
        errors++; $display("FAIL rand_counters: got %0d/%0d expected %0d/%0d",
                           branchCount, mispredictCount, mBrCnt, mMpCnt);
      end
`endif
      tick();
    end
    idle_e();
  endtask

`ifdef UCSBECE154B_BP_PERF_COUNTERS_EN
  task automatic test_perf_counters();
    do_reset();
    #1;
    checks++;
    if (branchCount !== 32'd0 || mispredictCount !== 32'd0) begin
      errors++; $display("FAIL perf_reset: got %0d/%0d expected 0/0", branchCount, mispredictCount);
    end
    drive_e(1, 0, 1, 1, 32'h00010100, 32'h00010200, 5'h01); tick();
    drive_e(1, 0, 0, 0, 32'h00010104, 32'h00010200, 5'h02); tick();
    idle_e();                                                tick();
    drive_e(1, 0, 1, 0, 32'h00010108, 32'h00010200, 5'h03); tick();
    idle_e();
    #1;
    checks++;
    if (branchCount !== 32'd3 || mispredictCount !== 32'd1) begin
      errors++; $display("FAIL perf_counts: got %0d/%0d expected 3/1", branchCount, mispredictCount);
    end
  endtask
`endif

  initial begin
    idle_e();
    bpIf.PCF_i = 32'd0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_jump();
    test_same_cycle();
    test_stale_hit();
    test_not_taken_alloc();
    test_branch_saturation();
    test_random();
`ifdef UCSBECE154B_BP_PERF_COUNTERS_EN
    test_perf_counters();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
